csr_irq_ctrl: RTL
=================

// Module: csr_irq_ctrl
// PURPOSE
// Machine-mode CSR and interrupt controller for the 5-stage RV32 core, generalised to NUM_IRQ sources.
// Owns mstatus/mie/mtvec/mepc/mcause/mip and a RUN/WFI/REQ/ACK trap FSM.
// Per-source edge/level pending, fixed priority and direct/vectored mtvec.
// Sits beside EXE; drives the pipeline stall, trap request and PC redirect.
// PARAMETERS
// NUM_IRQ      4             number of external sources, 1..16; source i -> mie/mip bit 16+i
// EDGE_MASK    4'b0011       bit i=1: source i edge-triggered (rising); 0: level
// MTVEC_RST    32'h0001_0000 mtvec reset value (direct mode)
// PORTS
// clk            in   1        clock
// rst            in   1        synchronous active-high reset
// irq_i          in   NUM_IRQ  raw interrupt lines (e.g. DMA done, WDT timeout)
// csr_valid      in   1        CSR instruction in EXE this cycle
// csr_op         in   2        01 RW, 10 RS, 11 RC; 00 = read only
// csr_addr       in   12       CSR address
// csr_wdata      in   32       rs1 value or zero-extended uimm
// csr_rdata      out  32       combinational old value of csr_addr
// csr_illegal    out  1        csr_valid with unimplemented address
// wfi_valid      in   1        WFI in EXE
// mret_valid     in   1        MRET in EXE
// trap_ack       in   1        pipeline drained; trap_epc valid
// trap_epc       in   32       PC of oldest unretired instruction
// trap_req       out  1        interrupt pending, pipeline must drain
// stall          out  1        freeze IF..EXE (WFI wait)
// redirect_valid out  1        one-cycle PC redirect pulse
// redirect_pc    out  32       redirect target
// BEHAVIOUR
// - Reset: mstatus.MIE=0, MPIE=0, mie=0, mip=0, mepc=0, mcause=0, mtvec=MTVEC_RST, FSM=RUN;
//   trap_req=0, stall=0, redirect_valid=0, redirect_pc=0. Reset mid-WFI/REQ aborts to RUN, drops pending.
// - irq_i registered once (irq_q). Edge source: mip bit sets when irq_q&~irq_q_d; clears on trap_ack taking it
//   or on CSR RW/RC clearing the bit. Level source: mip bit = irq_q each cycle; CSR writes ignored.
// - CSR: mstatus(0x300) MIE[3], MPIE[7] writable; mie(0x304) bits 16+i; mtvec(0x305) [31:2] base, [1:0] mode
//   (0 direct, 1 vectored, 2/3 write as 0); mepc(0x341) [1:0] forced 0; mcause(0x342); mip(0x344).
//   Unimplemented address: rdata=0, write ignored, csr_illegal=1. RS/RC with wdata=0 writes nothing.
// - active = mip & mie (bits 16..16+NUM_IRQ-1); winner = lowest index set.
// - FSM RUN: mret_valid -> MIE<=MPIE, MPIE<=1, redirect pulse to mepc (next cycle); mret beats any irq in the
//   same cycle, irq re-evaluated afterwards. Else MIE & |active -> REQ. Else wfi_valid -> WFI.
// - WFI: stall=1. |active (regardless of MIE) -> MIE ? REQ : RUN (WFI then completes as NOP).
// - REQ: trap_req=1, held until trap_ack; winner re-evaluated each cycle. If active drops to 0 before ack
//   (level line deasserted / mie cleared) -> RUN, trap_req falls, no trap.
// - trap_ack in REQ: mepc<=trap_epc, mcause<={1'b1,31'(16+winner)}, MPIE<=MIE, MIE<=0, clear edge mip[winner];
//   next cycle redirect_valid=1, redirect_pc = mode0 ? base : base+4*(16+winner); FSM -> RUN.
// - trap_ack outside REQ ignored. Same-cycle CSR write to mstatus/mepc/mcause loses to trap/mret update.
// - Latency: irq_i high at edge E0 -> mip at E1 -> trap_req from E2; redirect 1 cycle after trap_ack.
// TESTING
// 1 Reset, read all six CSRs -> mtvec=0x0001_0000, rest 0; csr_addr 0x7C0 -> rdata 0, csr_illegal=1.
// 2 mie=0x0001_0000, MIE=1, mtvec=0x2000 direct; pulse irq_i[0] 1 cycle -> trap_req 2 edges later; ack with
//   epc 0x104 -> mepc=0x104, mcause=0x8000_0010, MIE=0, MPIE=1, redirect_pc=0x2000, mip[16]=0.
// 3 Vectored mtvec=0x2001, irq 1 and 3 both active -> winner 1, redirect_pc=0x2044; after mret, source 3 taken
//   with redirect_pc=0x204C.
// 4 MIE=0, WFI, then level irq_i[2] high (mie[18]=1) -> stall falls, no trap_req, no redirect.
// 5 REQ pending on level irq_i[2]; drop line before ack -> trap_req falls, mcause unchanged.
// 6 mret_valid and new irq same cycle with MPIE=1 -> redirect to mepc first, trap_req next cycle; rst in REQ -> all reset values.

Source files
------------

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and interrupt controller for the RV32 core.
// Holds mstatus/mie/mtvec/mepc/mcause/mip, tracks per-source pending
// interrupts (edge or level), and runs the RUN/WFI/REQ trap FSM that
// stalls the front end, asks the pipeline to drain, and redirects the PC.
//
// Trap handshake: trap_req is held high while an enabled interrupt is
// pending in REQ. A trap is taken on the first cycle where trap_req and
// trap_ack are both high; trap_epc is sampled in that cycle. trap_ack
// while trap_req is low has no effect. If the pending interrupt vanishes
// before the ack, trap_req drops and nothing is taken.
module csr_irq_ctrl #(
   parameter int                 NUM_IRQ   = 4,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = 4'b0011,
   parameter logic [31:0]        MTVEC_RST = 32'h0001_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               csr_valid,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_illegal,
   input  logic               wfi_valid,
   input  logic               mret_valid,
   input  logic               trap_ack,
   input  logic [31:0]        trap_epc,
   output logic               trap_req,
   output logic               stall,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc,
   output logic [1:0]         fsm_state
);

   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_WFI = 2'd1;
   localparam logic [1:0] ST_REQ = 2'd2;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   logic [1:0]         state;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] irq_q_d;
   logic [NUM_IRQ-1:0] mip_q;
   logic [NUM_IRQ-1:0] mie_q;
   logic               mstatus_mie;
   logic               mstatus_mpie;
   logic [29:0]        mtvec_base;
   logic               mtvec_vec;
   logic [31:0]        mepc_q;
   logic [31:0]        mcause_q;

   logic [31:0]        mie_word;
   logic [31:0]        mip_word;
   logic [31:0]        csr_old;
   logic [31:0]        csr_new;
   logic               csr_hit;
   logic               csr_we;
   logic [NUM_IRQ-1:0] active;
   logic               any_active;
   logic [3:0]         winner;
   logic [NUM_IRQ-1:0] edge_clr;
   logic               take_trap;
   logic               do_mret;
   logic [31:0]        tvec_base;
   logic [31:0]        trap_target;
   logic [31:0]        trap_cause;

   // Place the per-source bits at their architectural positions 16+i.
   always_comb begin
      mie_word = '0;
      mip_word = '0;
      mie_word[16 +: NUM_IRQ] = mie_q;
      mip_word[16 +: NUM_IRQ] = mip_q;
   end

   // CSR read mux; the read value is the pre-write value of this cycle.
   always_comb begin
      csr_old = '0;
      csr_hit = 1'b1;
      case (csr_addr)
         A_MSTATUS: csr_old = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
         A_MIE:     csr_old = mie_word;
         A_MTVEC:   csr_old = {mtvec_base, 1'b0, mtvec_vec};
         A_MEPC:    csr_old = mepc_q;
         A_MCAUSE:  csr_old = mcause_q;
         A_MIP:     csr_old = mip_word;
         default:   csr_hit = 1'b0;
      endcase
   end

   // New CSR value for RW/RS/RC; RS/RC with a zero operand do not write.
   always_comb begin
      case (csr_op)
         OP_RW:   csr_new = csr_wdata;
         OP_RS:   csr_new = csr_old | csr_wdata;
         OP_RC:   csr_new = csr_old & ~csr_wdata;
         default: csr_new = csr_old;
      endcase
      csr_we = csr_valid && csr_hit && (csr_op != 2'b00) &&
               !(csr_op[1] && (csr_wdata == 32'd0));
   end

   assign csr_rdata   = csr_old;
   assign csr_illegal = csr_valid && !csr_hit;

   // Fixed priority: the lowest-numbered enabled pending source wins.
   always_comb begin
      active     = mip_q & mie_q;
      any_active = |active;
      winner     = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) winner = 4'(i);
      end
   end

   assign take_trap  = (state == ST_REQ) && any_active && trap_ack;
   assign do_mret    = (state == ST_RUN) && mret_valid;
   assign tvec_base  = {mtvec_base, 2'b00};
   assign trap_cause = {1'b1, 26'd0, 1'b1, winner};
   assign trap_target = mtvec_vec ? tvec_base + {25'd0, 1'b1, winner, 2'b00} : tvec_base;

   // Edge pending bits are cleared by taking that source or by a CSR clear.
   always_comb begin
      edge_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (take_trap && (winner == 4'(i))) edge_clr[i] = 1'b1;
         if (csr_we && (csr_addr == A_MIP) && (csr_op != OP_RS) && !csr_new[16+i])
            edge_clr[i] = 1'b1;
      end
   end

   // Single register stage on the raw lines plus a delayed copy for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q   <= '0;
         irq_q_d <= '0;
      end else begin
         irq_q   <= irq_i;
         irq_q_d <= irq_q;
      end
   end

   // Pending bits: edge sources latch a rising edge, level sources follow the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         mip_q <= '0;
      end else begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
               if (irq_q[i] && !irq_q_d[i]) mip_q[i] <= 1'b1;
               else if (edge_clr[i])        mip_q[i] <= 1'b0;
            end else begin
               mip_q[i] <= irq_q[i];
            end
         end
      end
   end

   // Architectural CSRs; trap entry and mret take precedence over a CSR write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mtvec_base   <= MTVEC_RST[31:2];
         mtvec_vec    <= (MTVEC_RST[1:0] == 2'b01);
         mepc_q       <= '0;
         mcause_q     <= '0;
      end else begin
         if (csr_we && (csr_addr == A_MIE))
            mie_q <= csr_new[16 +: NUM_IRQ];
         if (csr_we && (csr_addr == A_MTVEC)) begin
            mtvec_base <= csr_new[31:2];
            mtvec_vec  <= (csr_new[1:0] == 2'b01);
         end

         if (take_trap) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (do_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (csr_we && (csr_addr == A_MSTATUS)) begin
            mstatus_mie  <= csr_new[3];
            mstatus_mpie <= csr_new[7];
         end

         if (take_trap)
            mepc_q <= trap_epc & ~32'h3;
         else if (csr_we && (csr_addr == A_MEPC))
            mepc_q <= csr_new & ~32'h3;

         if (take_trap)
            mcause_q <= trap_cause;
         else if (csr_we && (csr_addr == A_MCAUSE))
            mcause_q <= csr_new;
      end
   end

   // Trap FSM and the one-cycle redirect pulse it issues on trap entry or mret.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= 1'b0;
         case (state)
            ST_RUN: begin
               if (mret_valid) begin
                  redirect_valid <= 1'b1;
                  redirect_pc    <= mepc_q;
               end else if (mstatus_mie && any_active) begin
                  state <= ST_REQ;
               end else if (wfi_valid) begin
                  state <= ST_WFI;
               end
            end
            ST_WFI: begin
               // Wake on any enabled pending source even with MIE clear.
               if (any_active) state <= mstatus_mie ? ST_REQ : ST_RUN;
            end
            ST_REQ: begin
               if (!any_active) begin
                  state <= ST_RUN;
               end else if (trap_ack) begin
                  state          <= ST_RUN;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= trap_target;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign trap_req  = (state == ST_REQ);
   assign stall     = (state == ST_WFI);
   assign fsm_state = state;

endmodule
